// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot path: loader state encoding and frame layout.
package mips_pkg;

    typedef enum logic [2:0] {
        LD_HDR_LO = 3'd0,
        LD_HDR_HI = 3'd1,
        LD_DATA   = 3'd2,
        LD_CSUM   = 3'd3,
        LD_DONE   = 3'd4,
        LD_ERR    = 3'd5
    } ld_state_e;

    localparam int LD_LEN_BYTES  = 2;
    localparam int LD_CSUM_BYTES = 1;

endpackage

// File: rtl/mips_prog_loader.sv
// Boot-time loader: receives a length-prefixed, checksummed byte frame and writes it into
// instruction memory, keeping the CPU in reset until a frame has loaded and verified.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [15:0]   MEM_LIMIT = 16'(MEM_BYTES);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    ld_state_e         state_q, state_d;
    logic              armed_q, armed_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    logic              xfer;
    logic [15:0]       hdr_len;
    logic [15:0]       cnt_ext;

    // armed_q keeps in_ready low during reset and for the cycle in which reset releases
    assign in_ready = armed_q && (state_q != LD_DONE) && (state_q != LD_ERR);
    assign xfer     = in_valid && in_ready;
    assign hdr_len  = {in_data, len_q[7:0]};
    assign cnt_ext  = 16'(cnt_q);

    always_comb begin
        state_d     = state_q;
        armed_d     = 1'b1;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        case (state_q)
            LD_HDR_LO: begin
                if (xfer) begin
                    len_d   = {8'h00, in_data};
                    state_d = LD_HDR_HI;
                end
            end
            LD_HDR_HI: begin
                if (xfer) begin
                    len_d = hdr_len;
                    if (hdr_len > MEM_LIMIT) begin
                        state_d    = LD_ERR;
                        load_err_d = 1'b1;
                    end else if (hdr_len == 16'd0) begin
                        state_d = LD_CSUM;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = in_data;
                    sum_d       = sum_q + in_data;
                    cnt_d       = cnt_q + CNT_ONE;
                    if (cnt_ext == len_q - 16'd1) begin
                        state_d = LD_CSUM;
                    end
                end
            end
            LD_CSUM: begin
                if (xfer) begin
                    if (in_data == sum_q) begin
                        state_d     = LD_DONE;
                        load_done_d = 1'b1;
                        cpu_rst_d   = 1'b0;
                    end else begin
                        state_d    = LD_ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            LD_DONE, LD_ERR: begin
                // Memory contents are left alone; a new frame overwrites what it covers
                if (reload) begin
                    state_d     = LD_HDR_LO;
                    len_d       = '0;
                    cnt_d       = '0;
                    sum_d       = '0;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    cpu_rst_d   = 1'b1;
                end
            end
            default: begin
                state_d = LD_HDR_LO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LD_HDR_LO;
            armed_q     <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule
